// File: rtl/modred_mont_iter.sv
// Word-serial Montgomery reduction: R = T * 2^-LOGQ mod Q over LOGQ/W digit iterations.
// Final conditional subtraction (R < Q) is present only when MODRED_FINAL_SUB_EN is defined.
module modred_mont_iter #(
    parameter int unsigned     LOGQ     = 60,
    parameter int unsigned     W        = 20,
    parameter logic [LOGQ-1:0] Q        = 60'hFFFFFFFFFFC0001,
    parameter logic [W-1:0]    QNEG_INV = 20'hBFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*LOGQ-1:0] T,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGQ:0]     R
);

    localparam int unsigned ITER = LOGQ / W;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam int unsigned AW   = 2 * LOGQ + 1;
    localparam int unsigned SW   = AW + 1;

`ifdef MODRED_FINAL_SUB_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SUB, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [LOGQ:0]   r_r;
    logic [W-1:0]    w_m;
    logic [SW-1:0]   w_sum;
    logic [AW-1:0]   w_acc_next;
    logic            w_last;

    // m chosen so the low W bits of ACC + m*Q cancel; the shift below is exact.
    assign w_m        = r_acc[W-1:0] * QNEG_INV;
    assign w_sum      = {1'b0, r_acc} + ({{(SW-W){1'b0}}, w_m} * {{(SW-LOGQ){1'b0}}, Q});
    assign w_acc_next = AW'(w_sum >> W);
    assign w_last     = (r_cnt == CW'(ITER - 1));

`ifdef MODRED_FINAL_SUB_EN
    logic [LOGQ:0] w_acc_lo;
    logic [LOGQ:0] w_sub_res;

    // ACC < 2Q after the iterations, so one conditional subtraction suffices.
    assign w_acc_lo  = r_acc[LOGQ:0];
    assign w_sub_res = (w_acc_lo >= {1'b0, Q}) ? (w_acc_lo - {1'b0, Q}) : w_acc_lo;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_RUN;
`ifdef MODRED_FINAL_SUB_EN
            S_RUN:  if (w_last) w_next = S_SUB;
            S_SUB:  w_next = S_DONE;
`else
            S_RUN:  if (w_last) w_next = S_DONE;
`endif
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_r   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc <= {1'b0, T};
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
`ifndef MODRED_FINAL_SUB_EN
                    if (w_last) r_r <= w_acc_next[LOGQ:0];
`endif
                end
`ifdef MODRED_FINAL_SUB_EN
                S_SUB: r_r <= w_sub_res;
`endif
                default: ;
            endcase
        end
    end

    assign R = r_r;

endmodule
